// File: rtl/axis_i2c_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : axis_i2c_bridge
// Brief    : AXI-Stream command word -> single-byte I2C master write/read.
//            Optional command FIFO selected by defining AXIS_I2C_FIFO_EN.
// Revision : 1.0
// =============================================================================
module axis_i2c_bridge #(
    parameter int unsigned QUARTER_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        i2c_scl_o,
    inout  wire         i2c_sda_io,
    output logic [7:0]  i2c_rdata_o,
    output logic        rvalid_o,
    output logic        busy_o,
    output logic        nack_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WDATA    = 4'd4,
        WACK     = 4'd5,
        RDATA    = 4'd6,
        RNACK    = 4'd7,
        STOP     = 4'd8
    } state_t;

    localparam int unsigned   c_QW    = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [c_QW-1:0] c_QLAST = c_QW'(QUARTER_CYCLES - 1);

    state_t          state_q,   state_d;
    logic [c_QW-1:0] qcnt_q,    qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_q,     bit_d;
    logic [15:0]     cmd_q,     cmd_d;
    logic [7:0]      rx_q,      rx_d;
    logic            ack_q,     ack_d;
    logic [7:0]      rdata_q,   rdata_d;
    logic            rvalid_q,  rvalid_d;
    logic            nack_q,    nack_d;

    logic        w_qend;
    logic        w_slot_end;
    logic        w_bit_last;
    logic        w_sda_in;
    logic        w_cmd_avail;
    logic [15:0] w_cmd_word;
    logic        w_cmd_take;
    logic        w_scl;
    logic        w_sda_low;
    logic [7:0]  w_tx_byte;

    assign w_qend     = (qcnt_q == c_QLAST);
    assign w_slot_end = w_qend && (quarter_q == 2'd3);
    assign w_bit_last = (bit_q == 3'd7);
    assign w_sda_in   = i2c_sda_io;
    assign w_cmd_take = (state_q == IDLE) && w_cmd_avail;

`ifdef AXIS_I2C_FIFO_EN
    localparam int unsigned c_AW = $clog2(FIFO_DEPTH);

    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q;
    logic [c_AW-1:0] rd_ptr_q;
    logic [c_AW:0]   count_q;
    logic            w_push;

    assign s_axis_tready = (count_q != (c_AW+1)'(FIFO_DEPTH));
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_cmd_avail   = (count_q != '0);
    assign w_cmd_word    = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_cmd_take) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            if (w_push && !w_cmd_take) begin
                count_q <= count_q + (c_AW+1)'(1);
            end else if (!w_push && w_cmd_take) begin
                count_q <= count_q - (c_AW+1)'(1);
            end
        end
    end
`else
    // Without a FIFO the engine takes the word straight off the bus in IDLE.
    assign s_axis_tready = (state_q == IDLE);
    assign w_cmd_avail   = s_axis_tvalid;
    assign w_cmd_word    = s_axis_tdata;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = w_qend ? '0 : qcnt_q + c_QW'(1);
        quarter_d = w_qend ? quarter_q + 2'd1 : quarter_q;
        bit_d     = bit_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        nack_d    = 1'b0;
        if (state_q == IDLE) begin
            qcnt_d    = '0;
            quarter_d = '0;
            bit_d     = '0;
            if (w_cmd_take) begin
                cmd_d   = w_cmd_word;
                state_d = START;
            end
        end else begin
            // SDA is sampled on the last clock of q1, mid-way through SCL high.
            if (w_qend && (quarter_q == 2'd1)) begin
                if ((state_q == ADDR_ACK) || (state_q == WACK)) begin
                    ack_d = w_sda_in;
                end
                if (state_q == RDATA) begin
                    rx_d = {rx_q[6:0], w_sda_in};
                end
            end
            if (w_slot_end) begin
                bit_d = '0;
                case (state_q)
                    START: state_d = ADDR;
                    ADDR: begin
                        bit_d = bit_q + 3'd1;
                        if (w_bit_last) state_d = ADDR_ACK;
                    end
                    ADDR_ACK: begin
                        if (ack_q) begin
                            nack_d  = 1'b1;
                            state_d = STOP;
                        end else begin
                            state_d = cmd_q[8] ? RDATA : WDATA;
                        end
                    end
                    WDATA: begin
                        bit_d = bit_q + 3'd1;
                        if (w_bit_last) state_d = WACK;
                    end
                    WACK: begin
                        nack_d  = ack_q;
                        state_d = STOP;
                    end
                    RDATA: begin
                        bit_d = bit_q + 3'd1;
                        if (w_bit_last) begin
                            rdata_d  = rx_q;
                            rvalid_d = 1'b1;
                            state_d  = RNACK;
                        end
                    end
                    RNACK:   state_d = STOP;
                    STOP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Bus pins decode directly from registered state so reset releases them at once.
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        w_tx_byte = (state_q == ADDR) ? cmd_q[15:8] : cmd_q[7:0];
        case (state_q)
            START: begin
                w_scl     = (quarter_q != 2'd3);
                w_sda_low = quarter_q[1];
            end
            STOP: begin
                w_scl     = (quarter_q != 2'd0);
                w_sda_low = ~quarter_q[1];
            end
            ADDR, WDATA: begin
                w_scl     = quarter_q[0] ^ quarter_q[1];
                w_sda_low = ~w_tx_byte[~bit_q];
            end
            ADDR_ACK, WACK, RDATA, RNACK: begin
                w_scl = quarter_q[0] ^ quarter_q[1];
            end
            default: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
        endcase
    end

    assign i2c_scl_o   = w_scl;
    assign i2c_sda_io  = w_sda_low ? 1'b0 : 1'bz;
    assign i2c_rdata_o = rdata_q;
    assign rvalid_o    = rvalid_q;
    assign nack_o      = nack_q;
    assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_i2c_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_axis_i2c_bridge
// Brief    : Vector table of single-byte I2C transactions checked against a
//            bus-level slave/monitor model, plus reset and flow-control cases.
// Revision : 1.0
// =============================================================================
module tb_axis_i2c_bridge;

    localparam int QC       = 2;
    localparam int FULL_CYC = 80 * QC;
    localparam int NACK_CYC = 44 * QC;
    localparam int NVEC     = 7;

    logic        clk    = 1'b0;
    logic        arst   = 1'b0;
    logic [15:0] tdata  = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        scl;
    wire         sda;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic        nack;

    logic        slave_low = 1'b0;
    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    axis_i2c_bridge #(
        .QUARTER_CYCLES (QC),
        .FIFO_DEPTH     (16)
    ) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .i2c_scl_o     (scl),
        .i2c_sda_io    (sda),
        .i2c_rdata_o   (rdata),
        .rvalid_o      (rvalid),
        .busy_o        (busy),
        .nack_o        (nack)
    );

    always #5 clk = ~clk;

    // Slave behaviour, set by the stimulus before each command.
    bit         sl_present = 1'b0;
    bit         sl_dack    = 1'b0;
    logic [7:0] sl_rbyte   = '0;

    // Bus monitor / slave model state (written only by the monitor process).
    int         starts = 0, stops = 0, rises = 0;
    int         nacks = 0, rvalids = 0, busys = 0, hs = 0;
    logic [7:0] seen [$];
    logic [7:0] m_addr = '0, m_data = '0, acc = '0;
    logic       m_ack0 = 1'b1, m_ack1 = 1'b1;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         bitn = 0, byten = 0;
    bit         in_txn = 1'b0;

    always @(negedge clk) begin
        if (arst) begin
            in_txn    = 1'b0;
            slave_low = 1'b0;
        end else begin
            if (nack)             nacks++;
            if (rvalid)           rvalids++;
            if (busy)             busys++;
            if (tvalid && tready) hs++;
            if (scl && scl_p && sda_p && !sda) begin
                starts++;
                in_txn = 1'b1; bitn = 0; byten = 0;
                m_addr = '0; m_data = '0; acc = '0; m_ack0 = 1'b1; m_ack1 = 1'b1;
                slave_low = 1'b0;
            end else if (in_txn && scl && scl_p && !sda_p && sda) begin
                stops++;
                in_txn = 1'b0;
                seen.push_back(m_data);
            end else if (in_txn && scl && !scl_p) begin
                rises++;
                if (bitn < 8) begin
                    acc = {acc[6:0], sda};
                    if (bitn == 7) begin
                        if (byten == 0)      m_addr = acc;
                        else if (byten == 1) m_data = acc;
                    end
                    bitn++;
                end else begin
                    if (byten == 0)      m_ack0 = sda;
                    else if (byten == 1) m_ack1 = sda;
                    bitn = 0;
                    byten++;
                end
            end else if (in_txn && !scl && scl_p) begin
                slave_low = 1'b0;
                if (byten == 0 && bitn == 8) begin
                    slave_low = sl_present;
                end else if (byten == 1 && sl_present) begin
                    if (m_addr[0]) begin
                        if (bitn < 8) slave_low = !sl_rbyte[7 - bitn];
                    end else if (bitn == 8) begin
                        slave_low = sl_dack;
                    end
                end
            end
        end
        scl_p = scl;
        sda_p = sda;
    end

    typedef struct {
        logic [15:0] tdata;
        bit          present;
        bit          dack;
        logic [7:0]  rbyte;
        logic [7:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_ack0;
        logic        e_ack1;
        int          e_busy;
        int          e_nack;
        int          e_rv;
        logic [7:0]  e_rdata;
        int          e_rises;
    } vec_t;

    vec_t vecs [NVEC];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, output bit ok);
        @(posedge clk); #1;
        tdata  = d;
        tvalid = 1'b1;
        ok     = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        repeat (4) @(negedge clk);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        int s0, p0, r0, n0, v0, b0;
        bit ok;
        sl_present = vecs[i].present;
        sl_dack    = vecs[i].dack;
        sl_rbyte   = vecs[i].rbyte;
        s0 = starts; p0 = stops; r0 = rises; n0 = nacks; v0 = rvalids; b0 = busys;
        send(vecs[i].tdata, ok);
        chk($sformatf("v%0d accept", i), ok, 1);
        wait_idle(ok);
        chk($sformatf("v%0d done", i), ok, 1);
        chk($sformatf("v%0d start", i), starts - s0, 1);
        chk($sformatf("v%0d stop", i), stops - p0, 1);
        chk($sformatf("v%0d addr byte", i), m_addr, vecs[i].e_addr);
        chk($sformatf("v%0d data byte", i), m_data, vecs[i].e_data);
        chk($sformatf("v%0d addr ack", i), m_ack0, vecs[i].e_ack0);
        chk($sformatf("v%0d data ack", i), m_ack1, vecs[i].e_ack1);
        chk($sformatf("v%0d scl rises", i), rises - r0, vecs[i].e_rises);
        chk($sformatf("v%0d busy cycles", i), busys - b0, vecs[i].e_busy);
        chk($sformatf("v%0d nack pulses", i), nacks - n0, vecs[i].e_nack);
        chk($sformatf("v%0d rvalid pulses", i), rvalids - v0, vecs[i].e_rv);
        chk($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
    endtask

    function automatic logic [15:0] fword(input int i);
        return {8'hA0, 8'(i * 7 + 3)};
    endfunction

    initial begin
        bit ok;
        // tdata, present, dack, rbyte | addr, data, ack0, ack1, busy, nack, rv, rdata, rises
        vecs[0] = '{16'hA455, 1'b1, 1'b1, 8'h00, 8'hA4, 8'h55, 1'b0, 1'b0, FULL_CYC, 0, 0, 8'h00, 19};
        vecs[1] = '{16'h7700, 1'b1, 1'b1, 8'hC3, 8'h77, 8'hC3, 1'b0, 1'b1, FULL_CYC, 0, 1, 8'hC3, 19};
        vecs[2] = '{16'h2080, 1'b0, 1'b0, 8'h00, 8'h20, 8'h00, 1'b1, 1'b1, NACK_CYC, 1, 0, 8'hC3, 10};
        vecs[3] = '{16'h9B00, 1'b0, 1'b0, 8'hFF, 8'h9B, 8'h00, 1'b1, 1'b1, NACK_CYC, 1, 0, 8'hC3, 10};
        vecs[4] = '{16'h5AFF, 1'b1, 1'b0, 8'h00, 8'h5A, 8'hFF, 1'b0, 1'b1, FULL_CYC, 1, 0, 8'hC3, 19};
        vecs[5] = '{16'hFF01, 1'b1, 1'b1, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b1, FULL_CYC, 0, 1, 8'h5A, 19};
        vecs[6] = '{16'h0000, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, FULL_CYC, 0, 0, 8'h5A, 19};

        #2 arst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset scl", scl, 1);
        chk("reset sda", sda, 1);
        chk("reset rdata", rdata, 0);
        chk("reset rvalid", rvalid, 0);
        chk("reset busy", busy, 0);
        chk("reset nack", nack, 0);
        chk("reset tready", tready, 1);
        arst = 1'b0;
        @(negedge clk);
        chk("post-reset tready", tready, 1);
        chk("post-reset busy", busy, 0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Reset during WDATA while the master holds SDA low with SCL low.
        sl_present = 1'b1;
        sl_dack    = 1'b1;
        send(16'hA455, ok);
        chk("midrst accept", ok, 1);
        repeat (103) @(negedge clk);
        chk("midrst busy before", busy, 1);
        chk("midrst scl low before", scl, 0);
        chk("midrst sda low before", sda, 0);
        #2 arst = 1'b1;
        #1;
        chk("midrst scl", scl, 1);
        chk("midrst sda released", sda, 1);
        chk("midrst busy", busy, 0);
        chk("midrst tready", tready, 1);
        chk("midrst rdata", rdata, 0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        run_vec(0);

`ifdef AXIS_I2C_FIFO_EN
        begin
            int base, n0, acc_n, wait_n;
            logic [15:0] w;
            sl_present = 1'b1;
            sl_dack    = 1'b1;
            base = seen.size();
            n0   = nacks;
            @(posedge clk); #1;
            tdata  = fword(0);
            tvalid = 1'b1;
            acc_n  = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!tready) break;
                @(posedge clk); #1;
                acc_n++;
                tdata = fword(acc_n);
            end
            // One word is popped into the engine while the other sixteen fill the FIFO.
            chk("fifo accepts before full", acc_n, 17);
            wait_n = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (tready) break;
                wait_n++;
            end
            @(posedge clk); #1;
            tvalid = 1'b0;
            chk("fifo extra word waits for pop", (wait_n > 100) ? 1 : 0, 1);
            for (int k = 0; k < 6000; k++) begin
                if (seen.size() - base >= 18) break;
                @(negedge clk);
            end
            chk("fifo transaction count", seen.size() - base, 18);
            for (int i = 0; i < 18; i++) begin
                w = fword(i);
                chk($sformatf("fifo order %0d", i), (base + i < seen.size()) ? int'(seen[base + i]) : -1, w[7:0]);
            end
            chk("fifo nacks", nacks - n0, 0);
            wait_idle(ok);
            chk("fifo drain idle", ok, 1);
        end
`else
        begin
            int h0, viol, cyc;
            sl_present = 1'b1;
            sl_dack    = 1'b1;
            h0 = hs;
            @(posedge clk); #1;
            tdata  = 16'hA455;
            tvalid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("hold first accept", ok, 1);
            @(posedge clk);
            viol = 0;
            cyc  = 0;
            @(negedge clk);
            while (busy && cyc < 2000) begin
                if (tready) viol++;
                cyc++;
                @(negedge clk);
            end
            chk("hold tready low while busy", viol, 0);
            chk("hold busy length", cyc, FULL_CYC);
            @(posedge clk); #1;
            tvalid = 1'b0;
            wait_idle(ok);
            chk("hold second done", ok, 1);
            chk("hold handshakes", hs - h0, 2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
